// File: rtl/free_list_pkg.sv
// Shared rename-stage constants and types used by the free list, map table and ROB.
package free_list_pkg;

  localparam int NUM_PREG = 64;
  localparam int NUM_AREG = 32;
  localparam int PREG_W   = 6;
  localparam int FL_DEPTH = NUM_PREG - NUM_AREG;

  typedef logic [PREG_W-1:0] preg_t;

endpackage

// File: rtl/free_list.sv
// Physical-register free list: circular buffer of unused preg IDs with a speculative
// head, a committed head for flush recovery, and a tail fed by retired mappings.
module free_list
  import free_list_pkg::*;
#(
  parameter int    PREG_W = free_list_pkg::PREG_W,
  parameter int    DEPTH  = free_list_pkg::FL_DEPTH,
  parameter string tag    = "FreeList"
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              alloc_req,
  output logic [PREG_W-1:0] alloc_preg,
  output logic              alloc_ok,
  input  logic              free_req,
  input  logic [PREG_W-1:0] free_preg,
  input  logic              commit_alloc,
  input  logic              flush,
  output logic [PREG_W-1:0] free_count,
  output logic              err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  // IDs above the architectural range seed the list; preg 0..NUM_AREG-1 start mapped.
  localparam int FIRST_FREE = (1 << PREG_W) - DEPTH;

  typedef logic [PTR_W-1:0] ptr_t;

  logic [PREG_W-1:0] mem [DEPTH];

  ptr_t head, chead, tail;
  ptr_t head_next, chead_next, tail_next;

  logic commit_ok;
  logic free_full;
  logic free_bad_id;
  logic free_ok;
  logic alloc_fire;
  logic err_event;

  assign alloc_ok   = (head != tail);
  assign alloc_preg = mem[head[IDX_W-1:0]];
  assign free_count = PREG_W'(tail - head);

  // Overflow is judged against the committed head: entries allocated but not yet
  // retired still occupy slots that a flush could hand back out.
  always_comb begin
    commit_ok   = commit_alloc && (chead != head);
    chead_next  = chead + ptr_t'(commit_ok);
    free_full   = ((tail - chead) == ptr_t'(DEPTH));
    free_bad_id = (free_preg == '0);
    free_ok     = free_req && !free_full && !free_bad_id;
    tail_next   = tail + ptr_t'(free_ok);
    alloc_fire  = alloc_req && alloc_ok && !stall && !flush;
    head_next   = flush ? chead_next : head + ptr_t'(alloc_fire);
    err_event   = (free_req && (free_full || free_bad_id)) || (commit_alloc && !commit_ok);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      chead <= '0;
      tail  <= ptr_t'(DEPTH);
      err   <= 1'b0;
    end else begin
      head  <= head_next;
      chead <= chead_next;
      tail  <= tail_next;
      err   <= err | err_event;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= PREG_W'(FIRST_FREE + i);
      end
    end else if (free_ok) begin
      mem[tail[IDX_W-1:0]] <= free_preg;
    end
  end

`ifdef FREELIST
  always_ff @(posedge clk) begin
    $display("%s head=%0d chead=%0d tail=%0d free_count=%0d", tag, head, chead, tail, free_count);
  end
`endif

endmodule

// File: tb/tb_free_list.sv
// Directed self-checking bench for free_list: allocation, free, commit, flush, wrap and errors.
module tb_free_list;

  logic       clk;
  logic       reset;
  logic       stall;
  logic       alloc_req;
  logic [5:0] alloc_preg;
  logic       alloc_ok;
  logic       free_req;
  logic [5:0] free_preg;
  logic       commit_alloc;
  logic       flush;
  logic [5:0] free_count;
  logic       err;

  int tests_run;
  int tests_failed;

  free_list #(
    .PREG_W(6),
    .DEPTH (32),
    .tag   ("FreeList")
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .alloc_req   (alloc_req),
    .alloc_preg  (alloc_preg),
    .alloc_ok    (alloc_ok),
    .free_req    (free_req),
    .free_preg   (free_preg),
    .commit_alloc(commit_alloc),
    .flush       (flush),
    .free_count  (free_count),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_stimulus(input logic a, input logic f, input logic [5:0] p,
                                input logic c, input logic fl, input logic s);
    alloc_req    = a;
    free_req     = f;
    free_preg    = p;
    commit_alloc = c;
    flush        = fl;
    stall        = s;
    #1;
  endtask

  task automatic check_output(input string name, input int observed, input int expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", name, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    #2 reset = 1'b1;
    #1;
    check_output("rst_err", err, 0);
    check_output("rst_preg", alloc_preg, 32);
    check_output("rst_count", free_count, 32);
    #1 reset = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    apply_stimulus(0, 0, 6'd0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_count", free_count, 32);
    check_output("reset_ok", alloc_ok, 1);
    check_output("reset_preg", alloc_preg, 32);
    check_output("reset_err", err, 0);
    reset = 1'b0;

    // Drain the whole list in order, then confirm the 33rd request is refused.
    for (int i = 0; i < 32; i++) begin
      apply_stimulus(1, 0, 6'd0, 0, 0, 0);
      check_output("drain_preg", alloc_preg, 32 + i);
      check_output("drain_ok", alloc_ok, 1);
      tick();
      check_output("drain_count", free_count, 31 - i);
    end
    check_output("empty_ok", alloc_ok, 0);
    tick();
    check_output("empty_count", free_count, 0);

    for (int i = 0; i < 32; i++) begin
      apply_stimulus(0, 0, 6'd0, 1, 0, 0);
      tick();
    end
    check_output("commit_err", err, 0);

    // Free into an empty list: no bypass, visible one cycle later.
    apply_stimulus(1, 1, 6'd5, 0, 0, 0);
    check_output("nobypass_ok", alloc_ok, 0);
    tick();
    check_output("freed_ok", alloc_ok, 1);
    check_output("freed_preg", alloc_preg, 5);
    check_output("freed_count", free_count, 1);
    apply_stimulus(1, 0, 6'd0, 0, 0, 0);
    tick();
    check_output("realloc_count", free_count, 0);
    apply_stimulus(0, 0, 6'd0, 1, 0, 0);
    tick();
    check_output("realloc_err", err, 0);

    // Releasing preg 0 is an error and must not move the tail.
    apply_stimulus(0, 1, 6'd0, 0, 0, 0);
    tick();
    check_output("zero_err", err, 1);
    check_output("zero_count", free_count, 0);
    check_output("zero_ok", alloc_ok, 0);
    apply_stimulus(0, 0, 6'd0, 0, 0, 0);
    reset_pulse();

    // Overflow right after reset: the write to slot 0 must be dropped.
    apply_stimulus(0, 1, 6'd9, 0, 0, 0);
    tick();
    check_output("ovf_err", err, 1);
    check_output("ovf_count", free_count, 32);
    check_output("ovf_preg", alloc_preg, 32);
    apply_stimulus(0, 0, 6'd0, 0, 0, 0);
    reset_pulse();

    // Commit with nothing outstanding: error, and chead must stay put.
    apply_stimulus(0, 0, 6'd0, 1, 0, 0);
    tick();
    check_output("cpast_err", err, 1);
    apply_stimulus(1, 0, 6'd0, 0, 0, 0);
    tick();
    check_output("cpast_preg", alloc_preg, 33);
    apply_stimulus(0, 0, 6'd0, 0, 1, 0);
    tick();
    check_output("cpast_flush_preg", alloc_preg, 32);
    check_output("cpast_flush_count", free_count, 32);
    apply_stimulus(0, 0, 6'd0, 0, 0, 0);
    reset_pulse();

    // Allocate 32,33,34, commit one, flush back to the committed head.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1, 0, 6'd0, 0, 0, 0);
      check_output("spec_preg", alloc_preg, 32 + i);
      tick();
    end
    apply_stimulus(0, 0, 6'd0, 1, 0, 0);
    tick();
    apply_stimulus(0, 0, 6'd0, 0, 1, 0);
    tick();
    check_output("flush_preg", alloc_preg, 33);
    check_output("flush_count", free_count, 31);
    check_output("flush_ok", alloc_ok, 1);

    // Flush together with commit, allocate and free(7).
    apply_stimulus(1, 0, 6'd0, 0, 0, 0);
    tick();
    apply_stimulus(1, 0, 6'd0, 0, 0, 0);
    tick();
    check_output("pre_combo_preg", alloc_preg, 35);
    apply_stimulus(1, 1, 6'd7, 1, 1, 0);
    tick();
    check_output("combo_preg", alloc_preg, 34);
    check_output("combo_count", free_count, 31);
    check_output("combo_err", err, 0);
    for (int i = 0; i < 30; i++) begin
      apply_stimulus(1, 0, 6'd0, 0, 0, 0);
      check_output("combo_walk_preg", alloc_preg, 34 + i);
      tick();
    end
    check_output("combo_tail_preg", alloc_preg, 7);
    check_output("combo_tail_count", free_count, 1);
    apply_stimulus(0, 0, 6'd0, 0, 0, 0);
    reset_pulse();

    // Steady-state alloc/free/commit across both index wrap points.
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1, 0, 6'd0, 0, 0, 0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(0, 0, 6'd0, 1, 0, 0);
      tick();
    end
    check_output("wrap_start_count", free_count, 27);
    check_output("wrap_start_preg", alloc_preg, 37);
    for (int i = 0; i < 40; i++) begin
      apply_stimulus(1, 1, 6'(i + 1), 1, 0, 0);
      check_output("wrap_preg", alloc_preg, (i < 27) ? 37 + i : i - 26);
      tick();
      check_output("wrap_count", free_count, 27);
    end
    check_output("wrap_err", err, 0);

    // Stall blocks allocation but not the free.
    apply_stimulus(1, 1, 6'd50, 0, 0, 1);
    check_output("stall_preg_before", alloc_preg, 14);
    tick();
    check_output("stall_preg_after", alloc_preg, 14);
    check_output("stall_count", free_count, 28);
    check_output("stall_err", err, 0);
    apply_stimulus(0, 0, 6'd0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
